// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel push-button conditioner.
// Each channel runs a 2-flop synchroniser, then a debounce counter, and
// produces a clean level plus one-cycle press/release strobes.
// e_debug bypasses the debounce timing so the level follows the
// synchronised input directly.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat press strobes while held).
module btn_debounce_multi #(
  parameter int N_CH          = 3,
  parameter int CLKS_TO_WAIT  = 2500000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            e_debug,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  localparam int CNT_W = $clog2(CLKS_TO_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_TO_WAIT - 1);

  // Refuse to elaborate with parameter values the counters cannot represent.
  if (N_CH < 1 || N_CH > 8 || CLKS_TO_WAIT < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce_multi: parameter out of range");
  end

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync;

  // Two-flop synchroniser for every raw pad input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_in;
      sync      <= sync_meta;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;
    logic             flip;
    logic             rpt_fire;

    // The level flips once the input has differed long enough, or at once in debug.
    always_comb begin
      flip = 1'b0;
      if (sync[g] != level) begin
        flip = e_debug || (cnt == CNT_LAST);
      end
    end

    // Stable-time counter; any return to the current level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (e_debug || (sync[g] == level) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;

    // A repeat fires while held, never in a cycle where the level is changing.
    always_comb begin
      rpt_fire = level && !flip &&
                 (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));
    end

    // Repeat timer: restarts on every level change, first interval is the long delay.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (flip || !level) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Debounced level and registered strobes, aligned with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        if (flip) begin
          level <= sync[g];
        end
        press <= (flip && sync[g]) || rpt_fire;
        rel   <= flip && !sync[g];
      end
    end

    assign btn_level[g]   = level;
    assign btn_press[g]   = press;
    assign btn_release[g] = rel;
  end

endmodule
